// File: rtl/out_fifo_write_arbiter.sv
// Write-port arbiter for the decompressor output byte FIFO: literal path vs copy-item engine.
// Copy bursts are locked until complete; literals and copy items alternate round-robin between items.
module out_fifo_write_arbiter #(
  parameter int COPY_MAX_LEN = 18,
  parameter int COPY_MIN_LEN = 3,
  parameter int LEN_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lit_valid_in,
  input  logic [7:0]           lit_data_in,
  output logic                 lit_ready_out,
  input  logic                 copy_req_in,
  input  logic [LEN_WIDTH-1:0] copy_len_in,
  output logic                 copy_grant_out,
  input  logic                 copy_valid_in,
  input  logic [7:0]           copy_data_in,
  output logic                 copy_ready_out,
  output logic                 copy_done_out,
  output logic                 len_err_out,
  input  logic                 fifo_full_in,
  output logic                 fifo_wr_en_out,
  output logic [7:0]           fifo_data_out
);

  typedef enum logic {ST_IDLE, ST_COPY} state_t;
  typedef enum logic {PRI_LIT, PRI_COPY} pri_t;

  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(COPY_MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(COPY_MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  pri_t                 pri_q, pri_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 grant_q, grant_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic copy_take;
  logic len_ok;
  logic lit_xfer;
  logic copy_xfer;

  assign len_ok = (copy_len_in >= MIN_LEN) && (copy_len_in <= MAX_LEN);

  always_comb begin
    state_d        = state_q;
    pri_d          = pri_q;
    rem_d          = rem_q;
    grant_d        = grant_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    copy_take      = 1'b0;
    lit_ready_out  = 1'b0;
    copy_ready_out = 1'b0;
    lit_xfer       = 1'b0;
    copy_xfer      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        copy_take     = copy_req_in & ((pri_q == PRI_COPY) | ~lit_valid_in);
        // Readies are forced low while reset is held, even though state already reads IDLE.
        lit_ready_out = ~reset & ~fifo_full_in & ~copy_take;
        lit_xfer      = lit_valid_in & lit_ready_out;
        if (lit_xfer) pri_d = PRI_COPY;
        if (copy_take) begin
          if (len_ok) begin
            state_d = ST_COPY;
            rem_d   = copy_len_in;
            grant_d = 1'b1;
          end else begin
            err_d = 1'b1;
            pri_d = PRI_LIT;
          end
        end
      end
      ST_COPY: begin
        copy_ready_out = ~reset & ~fifo_full_in;
        copy_xfer      = copy_valid_in & copy_ready_out;
        if (copy_xfer && (rem_q != '0)) begin
          rem_d = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = ST_IDLE;
            grant_d = 1'b0;
            done_d  = 1'b1;
            pri_d   = PRI_LIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pri_q   <= PRI_LIT;
      rem_q   <= '0;
      grant_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign copy_grant_out = grant_q;
  assign copy_done_out  = done_q;
  assign len_err_out    = err_q;
  assign fifo_wr_en_out = lit_xfer | copy_xfer;
  assign fifo_data_out  = (state_q == ST_COPY) ? copy_data_in : lit_data_in;

endmodule

// File: tb/tb_out_fifo_write_arbiter.sv
// Directed bench for out_fifo_write_arbiter: expected FIFO bytes are queued as stimulus is
// driven and popped whenever the DUT issues a write.
module tb_out_fifo_write_arbiter;

  logic       clk;
  logic       reset;
  logic       lit_valid_in;
  logic [7:0] lit_data_in;
  logic       lit_ready_out;
  logic       copy_req_in;
  logic [4:0] copy_len_in;
  logic       copy_grant_out;
  logic       copy_valid_in;
  logic [7:0] copy_data_in;
  logic       copy_ready_out;
  logic       copy_done_out;
  logic       len_err_out;
  logic       fifo_full_in;
  logic       fifo_wr_en_out;
  logic [7:0] fifo_data_out;

  int unsigned vectors;
  int unsigned miscompares;
  logic [7:0]  sb_q[$];

  out_fifo_write_arbiter #(
    .COPY_MAX_LEN(18),
    .COPY_MIN_LEN(3),
    .LEN_WIDTH   (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lit_valid_in  (lit_valid_in),
    .lit_data_in   (lit_data_in),
    .lit_ready_out (lit_ready_out),
    .copy_req_in   (copy_req_in),
    .copy_len_in   (copy_len_in),
    .copy_grant_out(copy_grant_out),
    .copy_valid_in (copy_valid_in),
    .copy_data_in  (copy_data_in),
    .copy_ready_out(copy_ready_out),
    .copy_done_out (copy_done_out),
    .len_err_out   (len_err_out),
    .fifo_full_in  (fifo_full_in),
    .fifo_wr_en_out(fifo_wr_en_out),
    .fifo_data_out (fifo_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, score any write, then advance to 1ns past the next edge.
  task automatic tick();
    #1;
    chk("no_wr_while_full", {31'd0, fifo_wr_en_out & fifo_full_in}, 32'd0);
    if (fifo_wr_en_out) begin
      if (sb_q.size() == 0) chk("unexpected_write", {31'd0, fifo_wr_en_out}, 32'd0);
      else                  chk("wr_data", {24'd0, fifo_data_out}, {24'd0, sb_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic g, input logic d, input logic e);
    chk({tag, "_grant"}, {31'd0, copy_grant_out}, {31'd0, g});
    chk({tag, "_done"},  {31'd0, copy_done_out},  {31'd0, d});
    chk({tag, "_err"},   {31'd0, len_err_out},    {31'd0, e});
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    lit_valid_in  = 1'b1;
    lit_data_in   = 8'h00;
    copy_req_in   = 1'b1;
    copy_len_in   = 5'd5;
    copy_valid_in = 1'b1;
    copy_data_in  = 8'h00;
    fifo_full_in  = 1'b0;

    // Reset state: outputs quiet even with every request asserted.
    #2;
    chk("rst_lit_ready",  {31'd0, lit_ready_out},  32'd0);
    chk("rst_copy_ready", {31'd0, copy_ready_out}, 32'd0);
    chk("rst_wr_en",      {31'd0, fifo_wr_en_out}, 32'd0);
    chk_regs("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset         = 1'b0;
    lit_valid_in  = 1'b0;
    copy_req_in   = 1'b0;
    copy_valid_in = 1'b0;

    // Four back-to-back literals.
    for (int i = 0; i < 4; i++) begin
      lit_valid_in = 1'b1;
      lit_data_in  = 8'hA0 + 8'(i);
      sb_q.push_back(lit_data_in);
      #1 chk("lit_wr_en", {31'd0, fifo_wr_en_out}, 32'd1);
      tick();
    end
    lit_valid_in = 1'b0;

    // Copy burst of 5 with no competing literal.
    copy_req_in   = 1'b1;
    copy_len_in   = 5'd5;
    copy_valid_in = 1'b1;
    #1 chk("take_no_wr", {31'd0, fifo_wr_en_out}, 32'd0);
    tick();
    chk_regs("c5_grant", 1'b1, 1'b0, 1'b0);
    copy_req_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      copy_data_in = 8'hC0 + 8'(i);
      sb_q.push_back(copy_data_in);
      #1 chk("c5_copy_ready", {31'd0, copy_ready_out}, 32'd1);
      tick();
      if (i < 4) chk_regs("c5_mid", 1'b1, 1'b0, 1'b0);
    end
    chk_regs("c5_end", 1'b0, 1'b1, 1'b0);
    copy_valid_in = 1'b0;
    tick();
    chk_regs("c5_after", 1'b0, 1'b0, 1'b0);

    // Literal and copy both pending right after reset: literal wins, then a 3-byte burst.
    reset = 1'b1;
    #3 reset = 1'b0;
    lit_valid_in = 1'b1;
    lit_data_in  = 8'h55;
    copy_req_in  = 1'b1;
    copy_len_in  = 5'd3;
    sb_q.push_back(8'h55);
    tick();
    chk_regs("rr_lit", 1'b0, 1'b0, 1'b0);
    lit_data_in = 8'h56;
    #1 chk("rr_lit_blocked", {31'd0, lit_ready_out}, 32'd0);
    tick();
    chk_regs("rr_grant", 1'b1, 1'b0, 1'b0);
    copy_req_in   = 1'b0;
    copy_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      copy_data_in = 8'hD0 + 8'(i);
      sb_q.push_back(copy_data_in);
      #1 chk("c3_lit_ready", {31'd0, lit_ready_out}, 32'd0);
      tick();
    end
    chk_regs("c3_end", 1'b0, 1'b1, 1'b0);
    copy_valid_in = 1'b0;
    sb_q.push_back(8'h56);
    #1 chk("c3_lit_next", {31'd0, fifo_wr_en_out}, 32'd1);
    tick();
    lit_valid_in = 1'b0;

    // Burst of 6 stalled by FIFO full with 3 bytes left.
    copy_req_in = 1'b1;
    copy_len_in = 5'd6;
    tick();
    chk_regs("c6_grant", 1'b1, 1'b0, 1'b0);
    copy_req_in   = 1'b0;
    copy_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      copy_data_in = 8'hE0 + 8'(i);
      sb_q.push_back(copy_data_in);
      tick();
    end
    fifo_full_in = 1'b1;
    copy_data_in = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      #1 chk("full_no_wr", {31'd0, fifo_wr_en_out}, 32'd0);
      chk("full_copy_ready", {31'd0, copy_ready_out}, 32'd0);
      tick();
      chk_regs("full_hold", 1'b1, 1'b0, 1'b0);
    end
    fifo_full_in = 1'b0;
    for (int i = 3; i < 6; i++) begin
      copy_data_in = 8'hE0 + 8'(i);
      sb_q.push_back(copy_data_in);
      #1 chk("c6_resume_wr", {31'd0, fifo_wr_en_out}, 32'd1);
      tick();
      if (i < 5) chk_regs("c6_mid", 1'b1, 1'b0, 1'b0);
    end
    chk_regs("c6_end", 1'b0, 1'b1, 1'b0);
    copy_valid_in = 1'b0;

    // Illegal lengths 2 and 19 are rejected.
    copy_req_in = 1'b1;
    copy_len_in = 5'd2;
    #1 chk("len2_no_wr", {31'd0, fifo_wr_en_out}, 32'd0);
    tick();
    chk_regs("len2", 1'b0, 1'b0, 1'b1);
    copy_len_in = 5'd19;
    #1 chk("len19_no_wr", {31'd0, fifo_wr_en_out}, 32'd0);
    tick();
    chk_regs("len19", 1'b0, 1'b0, 1'b1);
    copy_req_in = 1'b0;
    tick();
    chk_regs("len_after", 1'b0, 1'b0, 1'b0);

    // Reset mid-burst with rem=7.
    copy_req_in = 1'b1;
    copy_len_in = 5'd10;
    tick();
    chk_regs("c10_grant", 1'b1, 1'b0, 1'b0);
    copy_req_in   = 1'b0;
    copy_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      copy_data_in = 8'hF0 + 8'(i);
      sb_q.push_back(copy_data_in);
      tick();
    end
    reset = 1'b1;
    #1;
    chk_regs("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_copy_ready", {31'd0, copy_ready_out}, 32'd0);
    chk("mid_rst_lit_ready",  {31'd0, lit_ready_out},  32'd0);
    chk("mid_rst_wr_en",      {31'd0, fifo_wr_en_out}, 32'd0);
    #2 reset = 1'b0;
    copy_valid_in = 1'b0;
    copy_req_in   = 1'b1;
    copy_len_in   = 5'd4;
    lit_valid_in  = 1'b1;
    lit_data_in   = 8'h77;
    sb_q.push_back(8'h77);
    #1 chk("post_rst_lit_ready", {31'd0, lit_ready_out}, 32'd1);
    tick();
    chk_regs("post_rst", 1'b0, 1'b0, 1'b0);
    lit_valid_in = 1'b0;
    copy_req_in  = 1'b0;
    tick();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
